// File: rtl/mac_seq.sv
// ============================================================================
//  Module   : mac_seq
//  Brief    : Operand sequencer feeding an 8x8 multiply-accumulator to form
//             dot products of a commanded length.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mac_seq #(
  parameter int DW = 8,
  parameter int AW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          op_valid,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          op_ready,
  output logic [DW-1:0] mac_ina,
  output logic [DW-1:0] mac_inb,
  output logic          mac_clr,
  input  logic [AW-1:0] acc_in,
  output logic          res_valid,
  output logic [AW-1:0] res_data,
  input  logic          res_ready,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [LW-1:0] r_cnt;
  logic [LW-1:0] w_cnt;
  logic [DW-1:0] r_ina;
  logic [DW-1:0] r_inb;
  logic [DW-1:0] w_ina;
  logic [DW-1:0] w_inb;
  logic          r_mclr;
  logic          w_mclr;
  logic          r_rvalid;
  logic          w_rvalid;
  logic [AW-1:0] r_rdata;
  logic [AW-1:0] w_rdata;
  logic          w_accept;

  assign op_ready  = (r_state == S_RUN);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = op_valid && op_ready;
  assign mac_ina   = r_ina;
  assign mac_inb   = r_inb;
  assign mac_clr   = r_mclr;
  assign res_valid = r_rvalid;
  assign res_data  = r_rdata;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_ina    <= '0;
      r_inb    <= '0;
      r_mclr   <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt;
      r_ina    <= w_ina;
      r_inb    <= w_inb;
      r_mclr   <= w_mclr;
      r_rvalid <= w_rvalid;
      r_rdata  <= w_rdata;
    end
  end

  // Operand registers default to zero so idle cycles add nothing to the sum.
  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt;
    w_ina    = '0;
    w_inb    = '0;
    w_mclr   = 1'b0;
    w_rvalid = r_rvalid;
    w_rdata  = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            w_cnt  = len;
            w_mclr = 1'b1;
            w_next = S_CLEAR;
          end else begin
            w_rdata  = '0;
            w_rvalid = 1'b1;
            w_next   = S_DONE;
          end
        end
      end
      S_CLEAR: w_next = S_RUN;
      S_RUN: begin
        if (w_accept) begin
          w_ina = op_a;
          w_inb = op_b;
          w_cnt = r_cnt - LW'(1);
          if (r_cnt == LW'(1)) begin
            w_next = S_DRAIN1;
          end
        end
      end
      S_DRAIN1: w_next = S_DRAIN2;
      S_DRAIN2: begin
        w_rdata  = acc_in;
        w_rvalid = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          w_rvalid = 1'b0;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Operand sequencer that sits directly upstream of the 8x8 multiply-accumulator and computes dot products of length LEN.
- Accepts a start command with a vector length, then accepts operand pairs over a valid/ready stream.
- Drives the accumulator's operand inputs and its clear line, and reads back the 16-bit accumulator value.
- Returns the final sum on a valid/ready result port.

Parameters:
- DW, 8, operand width; must match the accumulator operand inputs.
- AW, 16, accumulator/result width; must match the accumulator output.
- LW, 8, width of the length field; maximum vector length 2^LW-1.

Ports:
- clk  input  1  single clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- start  input  1  begin a dot product; sampled only in IDLE.
- len  input  LW  element count; sampled with start.
- op_valid  input  1  operand pair present.
- op_a  input  DW  operand A.
- op_b  input  DW  operand B.
- op_ready  output  1  operand pair accepted when op_valid&&op_ready; combinational, equals (state==RUN).
- mac_ina  output  DW  registered operand to accumulator ina.
- mac_inb  output  DW  registered operand to accumulator inb.
- mac_clr  output  1  registered clear to accumulator clr.
- acc_in  input  AW  accumulator output.
- res_valid  output  1  result available.
- res_data  output  AW  dot-product result, modulo 2^AW.
- res_ready  input  1  result consumed when res_valid&&res_ready.
- busy  output  1  high whenever state!=IDLE.

Behaviour:
- Reset (clr high, async): state=IDLE.
  - mac_ina, mac_inb, mac_clr, res_valid, res_data, and the internal count all go to 0.
  - busy=0, op_ready=0.
- States: IDLE, CLEAR, RUN, DRAIN1, DRAIN2, DONE.
- IDLE:
  - start=1, len!=0: latch count=len, go to CLEAR, mac_clr<=1.
  - start=1, len==0: res_data<=0, res_valid<=1, go to DONE. The accumulator is not touched.
- CLEAR (exactly 1 cycle):
  - mac_clr is high for the whole cycle; mac_ina and mac_inb are 0.
  - Next edge: mac_clr<=0, go to RUN.
- RUN:
  - On acceptance: mac_ina<=op_a, mac_inb<=op_b, count<=count-1.
  - Without acceptance: mac_ina<=0, mac_inb<=0, so the accumulator adds 0 (stall tolerance).
  - Acceptance with count==1: go to DRAIN1.
- DRAIN1: mac_ina<=0, mac_inb<=0; the accumulator absorbs the last product at the next edge; go to DRAIN2.
- DRAIN2: acc_in holds the final sum; res_data<=acc_in, res_valid<=1, go to DONE.
- DONE:
  - res_valid and res_data are held stable until res_ready=1.
  - On res_ready=1 at the edge: res_valid<=0, go to IDLE.
  - start is ignored in DONE and in every other state except IDLE.
- Latency with no stalls: start sampled at edge 0, operands accepted at edges 2..len+1, res_valid high after edge len+3.
- Arithmetic: products and the sum wrap modulo 2^AW; no overflow flag.
- mac_ina and mac_inb are 0 in every state except the cycle after an acceptance.
- Reset mid-operation: everything returns to IDLE immediately; no partial result is emitted. The accumulator is cleared by the next start's CLEAR state.
- len=2^LW-1 is supported; count must not wrap.

Test Plan:
- Basic dot product: start, len=3, operand pairs (1,4),(2,5),(3,6) on consecutive cycles -> res_valid after edge 6, res_data=32, mac_clr high exactly 1 cycle.
- Wrap-around: len=2, pairs (255,255) twice -> res_data=16'hFC02, no extra flag.
- Stalls: len=4, pairs (2,3),(1,1),(4,4),(0,9) with op_valid low 1-3 cycles between them -> res_data=23; mac_ina/mac_inb are 0 during gaps; op_ready stays high in RUN.
- Zero length and result backpressure: start with len=0 -> res_valid one cycle later with res_data=0, no mac_clr pulse. Hold res_ready low 5 cycles and pulse start -> data stable, start ignored; res_ready=1 -> IDLE.
- Reset mid-run: len=5, assert clr after 2 accepted pairs -> all outputs 0 immediately. New start with len=1 and pair (7,7) -> res_data=49, with no residue from the aborted run.
- Back-to-back: two commands (len=1 pair (3,3); len=2 pairs (1,2),(2,2)) with res_ready held high -> results 9 then 6; busy drops for exactly 1 cycle between the commands.
